ps2_host_ctrl: RTL and testbench
================================

# ps2_host_ctrl

PS/2 host-side protocol controller that sequences the open-drain PS/2 pin driver. It consumes the driver's registered pin samples (`ps2_clk_d`, `ps2_data_d`) and produces its pull-low requests (`ps2_clk_q`, `ps2_data_q`). It receives device-to-host frames and transmits host-to-device command bytes, including the inhibit, request-to-send and ACK sequencing. It sits between the pin driver and the keyboard/mouse command logic of the programmer.

## Interface
- `FILTER_LEN`, 4: consecutive identical samples required before the filtered PS/2 clock changes state.
- `INHIBIT_CYCLES`, 5000: cycles the clock is held low before request-to-send (100 us at 50 MHz).
- `TIMEOUT_CYCLES`, 750000: watchdog limit in cycles without a filtered clock falling edge (15 ms at 50 MHz).

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ps2_clk_d`, `ps2_data_d` in 1: registered pin samples from the driver.
- `ps2_clk_q`, `ps2_data_q` out 1: 1 means pull the line low; 0 means release it.
- `tx_data` in 8: command byte.
- `tx_valid` in 1: command request.
- `tx_ready` out 1: a command can be accepted.
- `tx_done` out 1: one-cycle pulse when the device ACK is received.
- `tx_err` out 1: one-cycle pulse on timeout or missing ACK.
- `rx_data` out 8: last good received byte. Holds its value until the next good frame.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `rx_err` out 1: one-cycle pulse on a framing, parity or timeout error.
- `busy` out 1: the state is not IDLE.

## Operation
- **Input conditioning**
  - One extra sync stage on both inputs.
  - The clock passes through a `FILTER_LEN` glitch filter.
  - `fall` is a 1-cycle strobe on each 1→0 transition of the filtered clock.
  - Data is sampled at `fall` from the synced `ps2_data_d`.
- **States:** IDLE, RX, TX_INHIBIT, TX_RTS, TX_BITS, TX_ACK, TX_RECOVER.
- **IDLE**
  - `fall` → RX with `bitcnt` = 1. The sampled bit is the start bit.
  - Otherwise, `tx_valid && tx_ready` latches `tx_data` and computes odd parity, then goes to TX_INHIBIT.
  - If `fall` and `tx_valid` occur in the same cycle, RX wins and the command is not accepted.
  - `tx_ready` = (state == IDLE).
- **RX**
  - 11-bit frame: start (0), D0..D7 LSB first, odd parity, stop (1). One bit per `fall`.
  - After bit 11, return to IDLE.
  - If start = 0, stop = 1 and parity is good: update `rx_data` and pulse `rx_valid`.
  - Otherwise pulse `rx_err` and leave `rx_data` unchanged.
- **TX_INHIBIT**
  - `ps2_clk_q` = 1 for `INHIBIT_CYCLES`, then `ps2_data_q` = 1 (start bit), then → TX_RTS.
- **TX_RTS**
  - `ps2_clk_q` = 0 (release) while `ps2_data_q` is held at 1, then → TX_BITS.
- **TX_BITS**
  - On each `fall`, drive the next bit on `ps2_data_q` (`q` = ~bit): D0..D7, parity, then stop (release).
  - After the `fall` that releases for the stop bit → TX_ACK.
- **TX_ACK**
  - On the next `fall`, sample data. If it is 0, pulse `tx_done`; otherwise pulse `tx_err`.
  - Either way → TX_RECOVER.
- **TX_RECOVER**
  - Wait until both filtered clock and synced data are 1, then → IDLE.
- **Watchdog**
  - Counter clears on every `fall` and on every state entry. It runs in RX and in TX_RTS/TX_BITS/TX_ACK/TX_RECOVER.
  - When it reaches `TIMEOUT_CYCLES`:
    - In RX: pulse `rx_err`.
    - In any TX state: pulse `tx_err` and release both lines.
    - Then → IDLE.
- Parity is the XOR of D0..D7, inverted.

## Timing
- **Reset values** (asynchronous, immediate):
  - Both `*_q` outputs = 0 (lines released).
  - `rx_data` = 0x00.
  - `rx_valid`, `rx_err`, `tx_done`, `tx_err`, `busy` = 0; `tx_ready` = 1.
  - State = IDLE, filter output = 1.
- Reset mid-frame abandons the frame with no error pulse.
- **Pin-to-`fall` latency:** 1 cycle in the driver + 1 sync cycle + `FILTER_LEN` cycles.
- **`rx_valid`/`rx_err`** assert the cycle after the 11th `fall`.
- **`tx_ready`** deasserts the cycle after acceptance.
- **Line release:** `ps2_clk_q` rises the cycle after acceptance and falls exactly `INHIBIT_CYCLES` + 1 cycles later.
- **`tx_done`/`tx_err`** assert the cycle after the ACK `fall`.
- At most one of `rx_valid`, `rx_err`, `tx_done`, `tx_err` pulses in any cycle.

## Configuration
- `PS2_HOST_PARITY_CHECK_EN`
  - Defined: a parity mismatch in RX discards the byte and pulses `rx_err`.
  - Undefined: parity is ignored, so only start/stop/timeout errors pulse `rx_err` and the byte is delivered.
  - TX always generates correct parity in both builds.

## Test plan
- **RX good frame:** device model sends 0x1C with parity 0 → one `rx_valid` pulse, `rx_data` = 0x1C, no `rx_err`.
- **RX bad parity:** device sends 0x1C with parity 1.
  - With the macro → `rx_err` pulse and `rx_data` unchanged.
  - Without the macro → `rx_valid` and 0x1C.
- **TX command:** `tx_data` = 0xFF, `tx_valid` = 1 in IDLE.
  - → Clock held low 5000 cycles, then data low and clock released.
  - → Bits FF, parity 1 and stop observed on the model; the model ACKs with 0 → `tx_done` pulse, `tx_ready` = 1 after the lines go idle.
- **TX timeout:** the device never clocks after RTS → `tx_err` exactly 750000 cycles after clock release, both `*_q` = 0, back in IDLE.
- **Collision:** `tx_valid` in the same cycle as the first `fall` of a device frame → frame received normally, and the command is accepted only once IDLE returns.
- **Reset mid-RX:** assert `rst_n` = 0 after 5 bits → all outputs at their reset values immediately; the next full frame is received correctly.

Source files
------------

// File: rtl/ps2_host_ctrl.sv
// rtl/ps2_host_ctrl.sv - PS/2 host protocol controller: device frame receive, command transmit with inhibit/RTS/ACK.
// Optional RX parity checking is enabled by defining PS2_HOST_PARITY_CHECK_EN.
module ps2_host_ctrl #(
   parameter int FILTER_LEN     = 4,
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk_d,
   input  logic       ps2_data_d,
   output logic       ps2_clk_q,
   output logic       ps2_data_q,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_err,
   output logic       busy
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RX, S_TX_INHIBIT, S_TX_RTS, S_TX_BITS, S_TX_ACK, S_TX_RECOVER
   } state_t;

   state_t          state, state_n;
   logic            clk_s, data_s, filt, fall;
   logic [FW-1:0]   filt_cnt;
   logic [IW-1:0]   inh_cnt;
   logic [WW-1:0]   wd;
   logic [3:0]      cnt;
   logic [9:0]      rx_shift;
   logic [8:0]      tx_shift;
   logic            data_drv;
   logic            rx_err_r, tx_err_r;
   logic            accept, wd_run, timeout, inh_last;
   logic            rx_par_good, rx_par_ok, rx_frame_ok;

   // Sync stage plus glitch filter; fall is asserted in the first cycle the filtered clock is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s    <= 1'b1;
         data_s   <= 1'b1;
         filt     <= 1'b1;
         filt_cnt <= '0;
         fall     <= 1'b0;
      end else begin
         clk_s  <= ps2_clk_d;
         data_s <= ps2_data_d;
         fall   <= 1'b0;
         if (clk_s == filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt     <= clk_s;
            filt_cnt <= '0;
            fall     <= filt;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign inh_last    = (inh_cnt == IW'(INHIBIT_CYCLES));
   assign rx_par_good = ^rx_shift[9:1];
`ifdef PS2_HOST_PARITY_CHECK_EN
   assign rx_par_ok   = rx_par_good;
`else
   // Parity is still captured so the frame layout is identical in both builds.
   assign rx_par_ok   = rx_par_good | 1'b1;
`endif
   assign rx_frame_ok = !rx_shift[0] && data_s && rx_par_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      wd_run  = (state == S_RX) || (state == S_TX_RTS) || (state == S_TX_BITS) ||
                (state == S_TX_ACK) || (state == S_TX_RECOVER);
      timeout = wd_run && !fall && (wd == WW'(TIMEOUT_CYCLES - 1));
      case (state)
         S_IDLE: begin
            if (fall) begin
               state_n = S_RX;
            end else if (tx_valid) begin
               accept  = 1'b1;
               state_n = S_TX_INHIBIT;
            end
         end
         S_RX:         if (fall && cnt == 4'd10) state_n = S_IDLE;
         S_TX_INHIBIT: if (inh_last) state_n = S_TX_RTS;
         S_TX_RTS:     state_n = S_TX_BITS;
         S_TX_BITS:    if (fall && cnt == 4'd9) state_n = S_TX_ACK;
         S_TX_ACK:     if (fall) state_n = S_TX_RECOVER;
         S_TX_RECOVER: if (filt && data_s) state_n = S_IDLE;
         default:      state_n = S_IDLE;
      endcase
      if (timeout) state_n = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inh_cnt  <= '0;
         wd       <= '0;
         cnt      <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
         data_drv <= 1'b0;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         rx_err_r <= 1'b0;
         tx_done  <= 1'b0;
         tx_err_r <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_err_r <= 1'b0;
         tx_done  <= 1'b0;
         tx_err_r <= 1'b0;
         if (!wd_run || fall || state_n != state) wd <= '0;
         else                                      wd <= wd + 1'b1;
         if (state == S_TX_INHIBIT && state_n == S_TX_INHIBIT) inh_cnt <= inh_cnt + 1'b1;
         else                                                   inh_cnt <= '0;
         case (state)
            S_IDLE: begin
               if (fall) begin
                  cnt      <= 4'd1;
                  rx_shift <= {data_s, rx_shift[9:1]};
               end else if (accept) begin
                  cnt      <= 4'd0;
                  tx_shift <= {~^tx_data, tx_data};
                  data_drv <= 1'b1;
               end
            end
            S_RX: begin
               if (fall) begin
                  if (cnt == 4'd10) begin
                     if (rx_frame_ok) begin
                        rx_data  <= rx_shift[8:1];
                        rx_valid <= 1'b1;
                     end else begin
                        rx_err_r <= 1'b1;
                     end
                  end else begin
                     rx_shift <= {data_s, rx_shift[9:1]};
                     cnt      <= cnt + 1'b1;
                  end
               end
            end
            S_TX_BITS: begin
               if (fall) begin
                  if (cnt == 4'd9) begin
                     data_drv <= 1'b0;
                  end else begin
                     data_drv <= ~tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[8:1]};
                  end
                  cnt <= cnt + 1'b1;
               end
            end
            S_TX_ACK: begin
               if (fall) begin
                  if (!data_s) tx_done  <= 1'b1;
                  else         tx_err_r <= 1'b1;
               end
            end
            default: ;
         endcase
         if (timeout) data_drv <= 1'b0;
      end
   end

   assign ps2_clk_q  = (state == S_TX_INHIBIT);
   assign ps2_data_q = (state == S_TX_INHIBIT && inh_last) || (state == S_TX_RTS) ||
                       (state == S_TX_BITS && data_drv && !timeout);
   assign tx_ready   = (state == S_IDLE);
   assign busy       = (state != S_IDLE);
   assign tx_err     = tx_err_r | (timeout && state != S_RX);
   assign rx_err     = rx_err_r | (timeout && state == S_RX);

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// tb/tb_ps2_host_ctrl.sv - randomized bench for ps2_host_ctrl with a PS/2 device model and reference expectations.
module tb_ps2_host_ctrl;

   localparam int FL   = 4;
   localparam int INH  = 60;
   localparam int TO   = 3000;
   localparam int HALF = 20;
`ifdef PS2_HOST_PARITY_CHECK_EN
   localparam bit PCHK = 1'b1;
`else
   localparam bit PCHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk_d = 1'b1, ps2_data_d = 1'b1;
   logic       ps2_clk_q, ps2_data_q;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_err, rx_valid, rx_err, busy;
   logic [7:0] rx_data;
   logic       dev_clk = 1'b1, dev_data = 1'b1;
   logic       line_data;

   int checks = 0, failures = 0;
   int cyc = 0, rxv_cyc = 0;
   int n_rxv = 0, n_rxe = 0, n_txd = 0, n_txe = 0, n_multi = 0;
   logic [7:0] exp_rx = 8'h00;

   ps2_host_ctrl #(.FILTER_LEN(FL), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk_d(ps2_clk_d), .ps2_data_d(ps2_data_d),
      .ps2_clk_q(ps2_clk_q), .ps2_data_q(ps2_data_q), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_err(rx_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Open-drain lines plus the registering pin driver.
   assign line_data = dev_data & ~ps2_data_q;
   always @(posedge clk) begin
      ps2_clk_d  <= dev_clk & ~ps2_clk_q;
      ps2_data_d <= dev_data & ~ps2_data_q;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) begin n_rxv++; rxv_cyc = cyc; end
         if (rx_err)  n_rxe++;
         if (tx_done) n_txd++;
         if (tx_err)  n_txe++;
         if (int'(rx_valid) + int'(rx_err) + int'(tx_done) + int'(tx_err) > 1) n_multi++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference rule: start 0, stop 1, odd number of ones over data+parity (when checked).
   function automatic bit frame_ok(input logic [7:0] d, input int kind);
      logic p;
      p = ($countones(d) % 2 == 0) ^ (kind == 1);
      return (kind != 2) && (kind != 3) && (!PCHK || ($countones({d, p}) % 2 == 1));
   endfunction

   // kind: 0 good, 1 bad parity, 2 bad start, 3 bad stop
   task automatic send_frame(input logic [7:0] d, input int kind, input int nbits);
      logic [10:0] f;
      f = {(kind == 3) ? 1'b0 : 1'b1, ($countones(d) % 2 == 0) ^ (kind == 1), d, kind == 2};
      for (int i = 0; i < nbits; i++) begin
         dev_data = f[i];
         cyc_wait(HALF);
         dev_clk = 1'b0;
         cyc_wait(HALF);
         dev_clk = 1'b1;
      end
      cyc_wait(HALF);
      dev_data = 1'b1;
   endtask

   task automatic start_cmd(input logic [7:0] d);
      int n = 0;
      while (!tx_ready && n < 2000) begin cyc_wait(1); n++; end
      tx_data  = d;
      tx_valid = 1'b1;
      cyc_wait(1);
      chk("accept_clk_q", ps2_clk_q, 1);
      chk("accept_tx_ready", tx_ready, 0);
      tx_valid = 1'b0;
   endtask

   task automatic inhibit_phase();
      int hi = 0;
      while (ps2_clk_q === 1'b1 && hi < INH + 50) begin hi++; cyc_wait(1); end
      chk("inhibit_len", hi, INH + 1);
      chk("rts_data_low", ps2_data_q, 1);
   endtask

   task automatic dev_h2d(input logic [7:0] d, input bit ack);
      logic [9:0] bits;
      logic       st;
      int         d0, e0, n;
      inhibit_phase();
      cyc_wait(30);
      st = line_data;
      for (int j = 0; j < 10; j++) begin
         dev_clk = 1'b0;
         cyc_wait(HALF);
         dev_clk = 1'b1;
         cyc_wait(HALF - 2);
         bits[j] = line_data;
         cyc_wait(2);
      end
      chk("tx_start", st, 0);
      chk("tx_byte", bits[7:0], d);
      chk("tx_parity", bits[8], $countones(d) % 2 == 0);
      chk("tx_stop", bits[9], 1);
      d0 = n_txd; e0 = n_txe;
      dev_data = ~ack;
      cyc_wait(5);
      dev_clk = 1'b0;
      cyc_wait(HALF);
      dev_clk = 1'b1;
      cyc_wait(HALF);
      dev_data = 1'b1;
      n = 0;
      while (!tx_ready && n < 200) begin cyc_wait(1); n++; end
      chk("tx_ready_back", tx_ready, 1);
      chk("tx_done_cnt", n_txd - d0, ack);
      chk("tx_err_cnt", n_txe - e0, !ack);
   endtask

   initial begin
      logic [7:0] d, d2;
      int kind, v0, e0, c, n, q_cyc;
      bit ok, ack;

      #1;
      chk("reset_outs", {ps2_clk_q, ps2_data_q, rx_valid, rx_err, tx_done, tx_err, busy, tx_ready}, 8'b0000_0001);
      chk("reset_rx_data", rx_data, 8'h00);
      cyc_wait(3);
      rst_n = 1'b1;
      cyc_wait(10);

      for (int i = 0; i < 10; i++) begin
         d    = (i < 2) ? 8'h1C : 8'($urandom);
         kind = (i < 2) ? i : int'($urandom_range(0, 3));
         ok   = frame_ok(d, kind);
         v0 = n_rxv; e0 = n_rxe;
         send_frame(d, kind, 11);
         cyc_wait(10);
         if (ok) exp_rx = d;
         chk("rx_valid_cnt", n_rxv - v0, ok);
         chk("rx_err_cnt", n_rxe - e0, !ok);
         chk("rx_data", rx_data, exp_rx);
      end

      for (int i = 0; i < 4; i++) begin
         d   = (i == 0) ? 8'hFF : 8'($urandom);
         ack = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         start_cmd(d);
         dev_h2d(d, ack);
      end

      // TX with a silent device: watchdog must fire.
      start_cmd(8'($urandom));
      inhibit_phase();
      e0 = n_txe; c = 0;
      while (!tx_err && c < 2 * TO) begin cyc_wait(1); c++; end
      chk("tx_timeout_cycles", c, TO);
      chk("tx_timeout_lines", {ps2_clk_q, ps2_data_q}, 2'b00);
      cyc_wait(1);
      chk("tx_timeout_idle", {busy, tx_ready}, 2'b01);
      cyc_wait(2);
      chk("tx_timeout_err_cnt", n_txe - e0, 1);

      // Truncated device frame: RX watchdog.
      v0 = n_rxv; e0 = n_rxe;
      send_frame(8'($urandom), 0, 5);
      cyc_wait(TO + 100);
      chk("rx_timeout_err", n_rxe - e0, 1);
      chk("rx_timeout_valid", n_rxv - v0, 0);
      chk("rx_timeout_data", rx_data, exp_rx);

      // Command raised in the same cycle as the first fall of a device frame.
      d  = 8'($urandom);
      d2 = 8'($urandom);
      v0 = n_rxv;
      fork
         send_frame(d, 0, 11);
         begin
            @(negedge dev_clk);
            repeat (FL + 2) @(posedge clk);
            #1;
            tx_data  = d2;
            tx_valid = 1'b1;
            n = 0;
            while (!ps2_clk_q && n < 2000) begin cyc_wait(1); n++; end
            q_cyc    = cyc;
            tx_valid = 1'b0;
            chk("coll_accept_after_rx", q_cyc, rxv_cyc + 1);
            dev_h2d(d2, 1'b1);
         end
      join
      exp_rx = d;
      chk("coll_rx_cnt", n_rxv - v0, 1);
      chk("coll_rx_data", rx_data, exp_rx);

      // Reset in the middle of a frame.
      v0 = n_rxv; e0 = n_rxe;
      fork
         send_frame(8'($urandom), 0, 11);
         begin
            repeat (5) @(negedge dev_clk);
            cyc_wait(3);
            #2;
            rst_n = 1'b0;
            #1;
            chk("midrst_outs", {ps2_clk_q, ps2_data_q, rx_valid, rx_err, tx_done, tx_err, busy, tx_ready}, 8'b0000_0001);
            chk("midrst_rx_data", rx_data, 8'h00);
         end
      join
      cyc_wait(2);
      rst_n  = 1'b1;
      exp_rx = 8'h00;
      cyc_wait(20);
      chk("midrst_no_pulse", (n_rxv - v0) + (n_rxe - e0), 0);
      d = 8'($urandom);
      send_frame(d, 0, 11);
      cyc_wait(10);
      chk("postrst_rx_cnt", n_rxv - v0, 1);
      chk("postrst_rx_data", rx_data, d);

      chk("single_pulse", n_multi, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
